// File: rtl/core_pkg.sv
// Shared core definitions: op codes, memory access size encoding and the
// payload carried from the execute stage into the data-memory stage.
package core_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned OP_W  = 8;
    localparam int unsigned REG_W = 5;

    // Op codes (shared 8-bit encoding)
    localparam logic [OP_W-1:0] OP_ADD  = 8'd0;
    localparam logic [OP_W-1:0] OP_SB   = 8'd43;
    localparam logic [OP_W-1:0] OP_SH   = 8'd44;
    localparam logic [OP_W-1:0] OP_SW   = 8'd45;
    localparam logic [OP_W-1:0] OP_SD   = 8'd46;
    localparam logic [OP_W-1:0] OP_BEQ  = 8'd47;
    localparam logic [OP_W-1:0] OP_BNE  = 8'd48;
    localparam logic [OP_W-1:0] OP_BLT  = 8'd49;
    localparam logic [OP_W-1:0] OP_BGE  = 8'd50;
    localparam logic [OP_W-1:0] OP_BLTU = 8'd51;
    localparam logic [OP_W-1:0] OP_BGEU = 8'd52;
    localparam logic [OP_W-1:0] OP_JAL  = 8'd53;
    localparam logic [OP_W-1:0] OP_JALR = 8'd54;
    localparam logic [OP_W-1:0] OP_LB   = 8'd59;
    localparam logic [OP_W-1:0] OP_LH   = 8'd60;
    localparam logic [OP_W-1:0] OP_LW   = 8'd61;
    localparam logic [OP_W-1:0] OP_LBU  = 8'd62;
    localparam logic [OP_W-1:0] OP_LHU  = 8'd63;
    localparam logic [OP_W-1:0] OP_LWU  = 8'd64;
    localparam logic [OP_W-1:0] OP_LD   = 8'd65;

    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } mem_size_e;

    typedef struct packed {
        logic [OP_W-1:0]  instruction;
        logic [XLEN-1:0]  result;
        logic [XLEN-1:0]  store_data;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
        logic             is_store;
        mem_size_e        size;
        logic             is_unsigned;
    } mem_payload_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: an output register plus one skid slot.
// in_ready is a flop (no combinational path from out_ready).
// Ports: clk, reset (sync, active-high), flush (drops both entries),
//        in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module skid_buffer #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic skid_valid;
    T     skid_data;

    logic push;
    logic pop;
    logic out_valid_nxt;
    logic skid_valid_nxt;
    T     out_data_nxt;
    T     skid_data_nxt;

    // Next-state: output register refills from skid first, then from input
    always_comb begin
        push           = in_valid & in_ready;
        pop            = out_valid & out_ready;
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        skid_valid_nxt = skid_valid;
        skid_data_nxt  = skid_data;
        if (flush) begin
            out_valid_nxt  = 1'b0;
            skid_valid_nxt = 1'b0;
        end else if (!out_valid || pop) begin
            if (skid_valid) begin
                // in_ready is low while skid is occupied, so no push here
                out_valid_nxt  = 1'b1;
                out_data_nxt   = skid_data;
                skid_valid_nxt = 1'b0;
            end else begin
                out_valid_nxt = push;
                if (push) begin
                    out_data_nxt = in_data;
                end
            end
        end else if (push) begin
            skid_valid_nxt = 1'b1;
            skid_data_nxt  = in_data;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            skid_valid <= skid_valid_nxt;
            skid_data  <= skid_data_nxt;
            in_ready   <= !skid_valid_nxt;
        end
    end

endmodule

// File: rtl/execute_mem_stage.sv
// Execute -> memory pipeline stage: decodes load/store size and signedness,
// resolves branches/jumps into a one-cycle redirect, squashes the wrong-path
// op accepted during the redirect cycle, and buffers results in a skid buffer.
// Ports: clk, reset (sync, active-high), flush; ex_* upstream handshake and
//        operands; mem_* downstream payload; redirect_valid/redirect_pc to fetch.
module execute_mem_stage
    import core_pkg::*;
#(
    parameter int unsigned RESET_PC_INCR = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [OP_W-1:0]  ex_instruction,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic [XLEN-1:0]  ex_rs1_value,
    input  logic [XLEN-1:0]  ex_rs2_value,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_reg_write,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [OP_W-1:0]  mem_instruction,
    output logic [XLEN-1:0]  mem_result,
    output logic [XLEN-1:0]  mem_store_data,
    output logic [REG_W-1:0] mem_rd,
    output logic             mem_reg_write,
    output logic             mem_is_load,
    output logic             mem_is_store,
    output logic [1:0]       mem_size,
    output logic             mem_unsigned,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc
);

    mem_payload_t    payload;
    mem_payload_t    out_q;
    logic            is_branch;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            enq_valid;
    logic            accept;

    // Op decode, link value and redirect target
    always_comb begin
        payload             = '0;
        payload.instruction = ex_instruction;
        payload.result      = ex_alu_result;
        payload.store_data  = ex_rs2_value;
        payload.rd          = ex_rd;
        is_branch           = 1'b0;
        taken               = 1'b0;
        target              = ex_pc + ex_imm;
        case (ex_instruction)
            OP_SB: begin payload.is_store = 1'b1; payload.size = SIZE_BYTE;   end
            OP_SH: begin payload.is_store = 1'b1; payload.size = SIZE_HALF;   end
            OP_SW: begin payload.is_store = 1'b1; payload.size = SIZE_WORD;   end
            OP_SD: begin payload.is_store = 1'b1; payload.size = SIZE_DOUBLE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                is_branch = 1'b1;
                taken     = ex_alu_result[0];
            end
            OP_JAL: begin
                taken          = 1'b1;
                payload.result = ex_pc + XLEN'(RESET_PC_INCR);
            end
            OP_JALR: begin
                taken          = 1'b1;
                target         = (ex_rs1_value + ex_imm) & ~XLEN'(1);
                payload.result = ex_pc + XLEN'(RESET_PC_INCR);
            end
            OP_LB:  begin payload.is_load = 1'b1; payload.size = SIZE_BYTE;   end
            OP_LH:  begin payload.is_load = 1'b1; payload.size = SIZE_HALF;   end
            OP_LW:  begin payload.is_load = 1'b1; payload.size = SIZE_WORD;   end
            OP_LBU: begin payload.is_load = 1'b1; payload.size = SIZE_BYTE; payload.is_unsigned = 1'b1; end
            OP_LHU: begin payload.is_load = 1'b1; payload.size = SIZE_HALF; payload.is_unsigned = 1'b1; end
            OP_LWU: begin payload.is_load = 1'b1; payload.size = SIZE_WORD; payload.is_unsigned = 1'b1; end
            OP_LD:  begin payload.is_load = 1'b1; payload.size = SIZE_DOUBLE; end
            default: ;
        endcase
        payload.reg_write = ex_reg_write && (ex_rd != '0) && !is_branch && !payload.is_store;
    end

    // Ops arriving while a redirect is on the wire are wrong-path
    assign enq_valid = ex_valid & ~redirect_valid;
    assign accept    = enq_valid & ex_ready & ~flush;

    // Redirect pulse; flush overrides any redirect from the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= accept & taken;
            if (accept & taken) begin
                redirect_pc <= target;
            end
        end
    end

    skid_buffer #(
        .T (mem_payload_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (enq_valid),
        .in_ready  (ex_ready),
        .in_data   (payload),
        .out_valid (mem_valid),
        .out_ready (mem_ready),
        .out_data  (out_q)
    );

    assign mem_instruction = out_q.instruction;
    assign mem_result      = out_q.result;
    assign mem_store_data  = out_q.store_data;
    assign mem_rd          = out_q.rd;
    assign mem_reg_write   = out_q.reg_write;
    assign mem_is_load     = out_q.is_load;
    assign mem_is_store    = out_q.is_store;
    assign mem_size        = out_q.size;
    assign mem_unsigned    = out_q.is_unsigned;

endmodule

// File: tb/tb_execute_mem_stage.sv
// Bench for execute_mem_stage: a queue-based model of the stage's contents
// checked every cycle, plus directed vectors with literal expectations.
module tb_execute_mem_stage;

    logic        clk = 1'b0;
    logic        reset, flush, ex_valid, ex_ready, ex_reg_write;
    logic [7:0]  ex_instruction;
    logic [63:0] ex_alu_result, ex_rs1_value, ex_rs2_value, ex_imm, ex_pc;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_ready, mem_reg_write, mem_is_load, mem_is_store, mem_unsigned;
    logic [7:0]  mem_instruction;
    logic [63:0] mem_result, mem_store_data;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_size;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stall_from = -1;
    int stall_to   = -1;

    always #5 clk = ~clk;

    execute_mem_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instruction(ex_instruction),
        .ex_alu_result(ex_alu_result), .ex_rs1_value(ex_rs1_value), .ex_rs2_value(ex_rs2_value),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instruction(mem_instruction),
        .mem_result(mem_result), .mem_store_data(mem_store_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [7:0]  op;
        logic [63:0] result;
        logic [63:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic [1:0]  sz;
        logic        us;
    } exp_t;

    function automatic exp_t predict(input logic [7:0] op, input logic [63:0] alu, rs2, pc,
                                     input logic [4:0] rd, input logic rw);
        exp_t e;
        int   o = int'(op);
        bit   br   = (o >= 47 && o <= 52);
        bit   st   = (o >= 43 && o <= 46);
        bit   ld   = (o >= 59 && o <= 65);
        bit   link = (o == 53 || o == 54);
        e.op     = op;
        e.sdata  = rs2;
        e.rd     = rd;
        e.result = link ? pc + 64'd4 : alu;
        e.rw     = rw && (rd != 5'd0) && !br && !st;
        e.ld     = ld;
        e.st     = st;
        e.us     = (o == 62 || o == 63 || o == 64);
        e.sz     = 2'd0;
        if (st) e.sz = 2'(o - 43);
        case (o)
            60, 63: e.sz = 2'd1;
            61, 64: e.sz = 2'd2;
            65:     e.sz = 2'd3;
            default: ;
        endcase
        return e;
    endfunction

    exp_t        q[$];
    exp_t        e_new;
    bit          live = 0;
    bit          m_rv = 0;
    bit          m_zero = 0;
    logic [63:0] m_rpc = '0;
    bit          m_acc, m_tk;
    int          m_sz;

    always @(negedge clk) begin
        if (live) begin
            chk("ex_ready", 64'(ex_ready), 64'(q.size() < 2));
            chk("mem_valid", 64'(mem_valid), 64'(q.size() > 0));
            chk("redirect_valid", 64'(redirect_valid), 64'(m_rv));
            chk("redirect_pc", redirect_pc, m_rpc);
            if (q.size() > 0) begin
                chk("mem_instruction", 64'(mem_instruction), 64'(q[0].op));
                chk("mem_result", mem_result, q[0].result);
                chk("mem_store_data", mem_store_data, q[0].sdata);
                chk("mem_rd", 64'(mem_rd), 64'(q[0].rd));
                chk("mem_reg_write", 64'(mem_reg_write), 64'(q[0].rw));
                chk("mem_is_load", 64'(mem_is_load), 64'(q[0].ld));
                chk("mem_is_store", 64'(mem_is_store), 64'(q[0].st));
                chk("mem_size", 64'(mem_size), 64'(q[0].sz));
                chk("mem_unsigned", 64'(mem_unsigned), 64'(q[0].us));
            end else if (m_zero) begin
                chk("zero_result", mem_result, 64'd0);
                chk("zero_instruction", 64'(mem_instruction), 64'd0);
                chk("zero_store_data", mem_store_data, 64'd0);
            end
        end
        // advance model to the state after the coming edge
        if (reset) begin
            q.delete();
            m_rv = 0; m_rpc = '0; m_zero = 1; live = 1;
        end else if (flush) begin
            q.delete();
            m_rv = 0;
        end else begin
            m_sz  = q.size();
            m_acc = ex_valid && (m_sz < 2) && !m_rv;
            if (m_sz > 0 && mem_ready) void'(q.pop_front());
            if (m_acc) begin
                e_new = predict(ex_instruction, ex_alu_result, ex_rs2_value, ex_pc, ex_rd, ex_reg_write);
                q.push_back(e_new);
                m_zero = 0;
                m_tk = ((int'(ex_instruction) >= 47 && int'(ex_instruction) <= 52) && ex_alu_result[0])
                       || ex_instruction == 8'd53 || ex_instruction == 8'd54;
                m_rv = m_tk;
                if (m_tk)
                    m_rpc = (ex_instruction == 8'd54) ? ((ex_rs1_value + ex_imm) & ~64'd1)
                                                      : ex_pc + ex_imm;
            end else begin
                m_rv = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mem_ready = !(cyc >= stall_from && cyc <= stall_to);
    endtask

    task automatic drive(input logic [7:0] op, input logic [63:0] alu, rs1, rs2, imm, pc,
                         input logic [4:0] rd, input logic rw);
        ex_instruction = op; ex_alu_result = alu; ex_rs1_value = rs1; ex_rs2_value = rs2;
        ex_imm = imm; ex_pc = pc; ex_rd = rd; ex_reg_write = rw; ex_valid = 1'b1;
    endtask

    task automatic send(input logic [7:0] op, input logic [63:0] alu, rs1, rs2, imm, pc,
                        input logic [4:0] rd, input logic rw);
        logic took;
        int   n;
        drive(op, alu, rs1, rs2, imm, pc, rd, rw);
        took = 1'b0;
        n    = 0;
        while (!took && n < 50) begin
            took = ex_ready;
            step();
            n++;
        end
        chk("accept_timeout", 64'(took), 64'd1);
        ex_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b1;
        drive(8'd0, 0, 0, 0, 0, 0, 5'd0, 1'b0);
        ex_valid = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset_ex_ready", 64'(ex_ready), 64'd1);
        chk("reset_mem_valid", 64'(mem_valid), 64'd0);
        chk("reset_redirect_pc", redirect_pc, 64'd0);
        step();

        // ADD
        send(8'd0, 64'h5, 0, 0, 0, 64'h100, 5'd3, 1'b1);
        chk("add_valid", 64'(mem_valid), 64'd1);
        chk("add_result", mem_result, 64'h5);
        chk("add_reg_write", 64'(mem_reg_write), 64'd1);
        chk("add_rd", 64'(mem_rd), 64'd3);
        chk("add_no_redirect", 64'(redirect_valid), 64'd0);
        step();

        // Stream of 8 with back-pressure for three cycles
        stall_from = cyc + 2;
        stall_to   = cyc + 4;
        for (int i = 0; i < 8; i++)
            send(8'd0, 64'h100 + 64'(i), 0, 64'(i), 0, 64'h200 + 64'(4 * i), 5'(i + 1), 1'b1);
        stall_from = -1; stall_to = -1;
        repeat (4) step();

        // Taken BEQ, then a wrong-path ADD in the redirect cycle
        send(8'd47, 64'd1, 0, 0, 64'h20, 64'h1000, 5'd5, 1'b1);
        chk("beq_redirect_valid", 64'(redirect_valid), 64'd1);
        chk("beq_redirect_pc", redirect_pc, 64'h1020);
        chk("beq_reg_write", 64'(mem_reg_write), 64'd0);
        drive(8'd0, 64'h99, 0, 0, 0, 64'h1004, 5'd7, 1'b1);
        chk("squash_ex_ready", 64'(ex_ready), 64'd1);
        step();
        ex_valid = 1'b0;
        chk("squash_redirect_off", 64'(redirect_valid), 64'd0);
        chk("squash_dropped", 64'(mem_valid), 64'd0);
        step();

        // Not-taken BNE
        send(8'd48, 64'd0, 0, 0, 64'h40, 64'h1100, 5'd0, 1'b0);
        chk("bne_no_redirect", 64'(redirect_valid), 64'd0);
        // JAL
        send(8'd53, 64'h0, 0, 0, 64'h100, 64'h300, 5'd1, 1'b1);
        step();
        // JALR
        send(8'd54, 64'h0, 64'h2003, 0, 64'h4, 64'h400, 5'd1, 1'b1);
        chk("jalr_redirect_pc", redirect_pc, 64'h2006);
        chk("jalr_result", mem_result, 64'h404);
        step();

        // LHU then SD
        send(8'd63, 64'h80, 0, 0, 0, 64'h500, 5'd4, 1'b1);
        chk("lhu_is_load", 64'(mem_is_load), 64'd1);
        chk("lhu_size", 64'(mem_size), 64'd1);
        chk("lhu_unsigned", 64'(mem_unsigned), 64'd1);
        chk("lhu_addr", mem_result, 64'h80);
        send(8'd46, 64'h88, 0, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'h504, 5'd6, 1'b1);
        chk("sd_is_store", 64'(mem_is_store), 64'd1);
        chk("sd_size", 64'(mem_size), 64'd3);
        chk("sd_store_data", mem_store_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk("sd_reg_write", 64'(mem_reg_write), 64'd0);

        // Other loads/stores and an unknown op
        send(8'd59, 64'h90, 0, 0, 0, 64'h508, 5'd8, 1'b1);
        send(8'd64, 64'h94, 0, 0, 0, 64'h50c, 5'd8, 1'b1);
        send(8'd65, 64'h98, 0, 0, 0, 64'h510, 5'd8, 1'b1);
        send(8'd44, 64'h9c, 0, 64'h1234, 0, 64'h514, 5'd8, 1'b1);
        send(8'd200, 64'h77, 0, 0, 64'h8, 64'h518, 5'd9, 1'b1);
        chk("unknown_not_mem", 64'({mem_is_load, mem_is_store}), 64'd0);
        chk("unknown_no_redirect", 64'(redirect_valid), 64'd0);

        // JAL with pc wrap
        send(8'd53, 64'h0, 0, 0, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC, 5'd2, 1'b1);
        chk("wrap_redirect_pc", redirect_pc, 64'h4);
        chk("wrap_result", mem_result, 64'h0);
        repeat (3) step();

        // Flush with both entries full and a redirect pending
        stall_from = 0; stall_to = 1000000;
        send(8'd0, 64'h11, 0, 0, 0, 64'h600, 5'd3, 1'b1);
        send(8'd53, 64'h0, 0, 0, 64'h40, 64'h604, 5'd1, 1'b1);
        chk("pre_flush_ex_ready", 64'(ex_ready), 64'd0);
        chk("pre_flush_redirect", 64'(redirect_valid), 64'd1);
        drive(8'd0, 64'h22, 0, 0, 0, 64'h608, 5'd3, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0; ex_valid = 1'b0;
        chk("flush_mem_valid", 64'(mem_valid), 64'd0);
        chk("flush_redirect", 64'(redirect_valid), 64'd0);
        chk("flush_ex_ready", 64'(ex_ready), 64'd1);
        step();

        // Reset mid-stream with both entries full and a redirect pending
        send(8'd200, 64'h33, 0, 64'h44, 0, 64'h700, 5'd3, 1'b1);
        send(8'd54, 64'h0, 64'h900, 0, 64'h10, 64'h704, 5'd1, 1'b1);
        chk("pre_reset_redirect", 64'(redirect_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_redirect", 64'(redirect_valid), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_mem_result", mem_result, 64'd0);
        chk("rst_mem_instruction", 64'(mem_instruction), 64'd0);
        chk("rst_redirect_pc", redirect_pc, 64'd0);
        stall_from = -1; stall_to = -1;
        mem_ready = 1'b1;
        step();
        send(8'd0, 64'h55, 0, 0, 0, 64'h800, 5'd10, 1'b1);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_mem_stage.md
Name: execute_mem_stage

Overview:
- Pipeline stage between the execute ALU and the data-memory stage.
- Registers each execute-stage result behind a 2-entry valid/ready skid buffer.
- Resolves branches and jumps from the ALU compare result, and issues a one-cycle PC redirect.
- Decorates load/store ops with access size and signedness for the memory stage.

Parameters:
XLEN, 64, datapath width
RESET_PC_INCR, 4, link offset added to pc for JAL/JALR

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  trap/exception flush; kills everything held in this stage
ex_valid  in  1  execute result valid
ex_ready  out  1  stage can accept (registered)
ex_instruction  in  8  op code (shared 8-bit encoding)
ex_alu_result  in  XLEN  ALU result: branch compare (0/1), effective address, or arithmetic result
ex_rs1_value  in  XLEN  rs1 operand (JALR base)
ex_rs2_value  in  XLEN  rs2 operand (store data)
ex_imm  in  XLEN  sign-extended immediate
ex_pc  in  XLEN  instruction pc
ex_rd  in  5  destination register
ex_reg_write  in  1  writes rd
mem_valid  out  1  output valid
mem_ready  in  1  memory stage accepts
mem_instruction  out  8  op code
mem_result  out  XLEN  address (ld/st), pc+4 (JAL/JALR), else ALU result
mem_store_data  out  XLEN  rs2 value
mem_rd  out  5  destination
mem_reg_write  out  1  forced 0 for branches/stores and for rd==0
mem_is_load / mem_is_store  out  1 each  op class
mem_size  out  2  0=byte,1=half,2=word,3=double
mem_unsigned  out  1  LBU/LHU/LWU
redirect_valid  out  1  one-cycle pulse: fetch must restart
redirect_pc  out  XLEN  new pc

Behaviour:
- Reset (sync, active-high): mem_valid=0, redirect_valid=0, redirect_pc=0, skid empty, ex_ready=1 the cycle after reset deasserts; all data outputs 0.
- Accept: ex_valid & ex_ready. Transfer out: mem_valid & mem_ready.
- Output register:
  - Loads when empty or transferring out.
  - Otherwise the accepted entry goes to the skid register.
- ex_ready = !skid_valid (registered; no combinational path from mem_ready).
- When the output register drains, the skid entry moves to the output register.
- Full throughput with mem_ready held high; latency 1 cycle.
- Order is preserved; an entry is never duplicated or lost.
- Decode at accept:
  - Branches 47..52: taken iff ex_alu_result[0]; target = ex_pc+ex_imm.
  - JAL 53: target = ex_pc+ex_imm.
  - JALR 54: target = (ex_rs1_value+ex_imm) & ~1.
  - Stores 43..46 → is_store, size 0..3.
  - Loads 59..65: LB=0, LH=1, LW=2, LBU=0u, LHU=1u, LWU=2u, LD=3.
- Redirect:
  - Fires for a taken branch, JAL, or JALR.
  - redirect_valid is registered high for exactly one cycle after the accept, with redirect_pc = target.
- Wrong-path squash:
  - Any ex accept occurring in the cycle redirect_valid=1 is discarded (ex_ready still 1, nothing enqueued).
  - Branches still enter mem as bubbles-with-valid (reg_write=0) so retirement counts stay exact.
- Flush:
  - Both entries are cleared; mem_valid=0 and redirect_valid=0 next cycle.
  - An accept in the flush cycle is dropped.
  - Flush has priority over accept, transfer, and redirect.
- Reset mid-operation behaves identically to flush, and also zeroes data.
- Simultaneous drain + accept while skid is full is impossible (ex_ready=0). With skid empty, out full, and no drain, the accept goes to skid and ex_ready drops next cycle.
- Unknown op codes pass through with is_load=is_store=0 and no redirect.
- All adds are modulo 2^XLEN; wrap is silent.

Decomposition:
- Shared package (core_pkg): op-code localparams (ADD..LD, 8-bit), mem_size enum, and the ex/mem payload struct (instruction, result, store_data, rd, reg_write, load/store, size, unsigned).
- Sub-module skid_buffer (parameterised on payload type/width) holds the valid/ready logic.
- This module holds decode, target computation, redirect, and squash.

Test Plan:
- ADD result 0x5, rd=3, mem_ready=1 → mem_valid next cycle, mem_result=0x5, reg_write=1; no redirect.
- Stream 8 ops with mem_ready low for cycles 2-4 → ex_ready drops after 2 held; order intact, no loss/dup, throughput 1/cycle once ready.
- BEQ pc=0x1000, imm=0x20, alu_result=1 → redirect_valid one cycle, redirect_pc=0x1020. The op accepted that cycle is dropped. The branch exits with reg_write=0.
- JALR rs1=0x2003, imm=0x4, pc=0x400 → redirect_pc=0x2006, mem_result=0x404.
- LHU addr 0x80 → is_load=1, size=1, unsigned=1. SD → is_store=1, size=3, store_data=rs2.
- flush while both entries full and redirect pending → next cycle mem_valid=0, redirect_valid=0, ex_ready=1. Reset mid-stream gives the same, with data outputs 0.
